// File: rtl/div_issue_iter_if.sv
// div_issue_iter_if: handshake bundle between the div issue queue, the
// iterative divide unit and the CDB arbiter.
//   master : environment side (queue head, flush, CDB grant)
//   slave  : the divide unit
interface div_issue_iter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
);
    // issue queue side
    logic               issue_queue_rdy;
    logic [1:0]         op;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [TAG_W-1:0]   rd_tag;
    logic               read_enable;

    // pipeline control / status
    logic               flush;
    logic               busy;

    // CDB side
    logic               cdb_grant;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [XLEN-1:0]    cdb_result;
    logic               cdb_branch;
    logic               issue_done;

    modport master (
        output issue_queue_rdy, op, rs1_data, rs2_data, rd_tag, flush, cdb_grant,
        input  read_enable, busy, cdb_valid, cdb_tag, cdb_result, cdb_branch, issue_done
    );

    modport slave (
        input  issue_queue_rdy, op, rs1_data, rs2_data, rd_tag, flush, cdb_grant,
        output read_enable, busy, cdb_valid, cdb_tag, cdb_result, cdb_branch, issue_done
    );
endinterface

// File: rtl/div_issue_iter.sv
// div_issue_iter: iterative radix-2 restoring divide issue unit.
// Pops one op (DIV/DIVU/REM/REMU) from the div issue queue, iterates for
// XLEN cycles, then holds the result on the CDB until granted.
// Optional feature macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed
// overflow skip the iteration and complete the cycle after accept.
module div_issue_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    div_issue_iter_if.slave  bus
);

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam int unsigned   CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [XLEN-1:0]    rem_q,     rem_d;      // partial remainder
    logic [XLEN-1:0]    quo_q,     quo_d;      // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]    dvs_q,     dvs_d;      // divisor magnitude
    logic               rem_sel_q, rem_sel_d;  // 1: REM/REMU, 0: DIV/DIVU
    logic               q_neg_q,   q_neg_d;
    logic               r_neg_q,   r_neg_d;
    logic               ovr_q,     ovr_d;      // special case: override value wins
    logic [XLEN-1:0]    ovr_val_q, ovr_val_d;
    logic [TAG_W-1:0]   tag_q,     tag_d;
    logic               valid_q,   valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]    res_q,     res_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               read_en;
    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               div_zero;
    logic               sgn_ovf;
    logic               special;
    logic [XLEN-1:0]    spec_val;

    logic [XLEN:0]      trial;
    logic [XLEN-1:0]    step_rem;
    logic [XLEN-1:0]    step_quo;
    logic [XLEN-1:0]    fin_quo;
    logic [XLEN-1:0]    fin_rem;
    logic [XLEN-1:0]    fin_res;

    // Queue pop: only when idle, or when the held result retires this cycle.
    always_comb begin
        read_en = rst_n && bus.issue_queue_rdy && !bus.flush &&
                  ((state_q == IDLE) || ((state_q == DONE) && bus.cdb_grant));
    end

    // Operand preparation at accept: magnitudes, signs and special-case value.
    always_comb begin
        sgn_op   = ~bus.op[0];
        a_neg    = sgn_op & bus.rs1_data[XLEN-1];
        b_neg    = sgn_op & bus.rs2_data[XLEN-1];
        a_mag    = a_neg ? (XLEN'(0) - bus.rs1_data) : bus.rs1_data;
        b_mag    = b_neg ? (XLEN'(0) - bus.rs2_data) : bus.rs2_data;
        div_zero = (bus.rs2_data == '0);
        sgn_ovf  = sgn_op && (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
        special  = div_zero | sgn_ovf;
        if (div_zero) begin
            spec_val = bus.op[1] ? bus.rs1_data : '1;
        end else begin
            spec_val = bus.op[1] ? '0 : bus.rs1_data;
        end
    end

    // One restoring-division step plus sign correction of the step's output.
    // The final result is formed from the last step's output so that it can be
    // registered on the same edge that enters DONE.
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
            step_rem = trial[XLEN-1:0];
            step_quo = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            step_rem = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            step_quo = {quo_q[XLEN-2:0], 1'b0};
        end
        fin_quo = q_neg_q ? (XLEN'(0) - step_quo) : step_quo;
        fin_rem = r_neg_q ? (XLEN'(0) - step_rem) : step_rem;
        fin_res = ovr_q ? ovr_val_q : (rem_sel_q ? fin_rem : fin_quo);
    end

    // Next-state and datapath update: iterate, complete, retire, accept, flush.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_sel_d = rem_sel_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        ovr_d     = ovr_q;
        ovr_val_d = ovr_val_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        cdb_tag_d = cdb_tag_q;
        res_d     = res_q;

        case (state_q)
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    res_d     = fin_res;
                    cdb_tag_d = tag_q;
                    valid_d   = 1'b1;
                end
            end
            DONE: begin
                if (bus.cdb_grant) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept overrides the DONE retire path so back-to-back ops enter CALC directly.
        if (read_en) begin
            state_d   = CALC;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            rem_sel_d = bus.op[1];
            q_neg_d   = a_neg ^ b_neg;
            r_neg_d   = a_neg;
            ovr_d     = special;
            ovr_val_d = spec_val;
            tag_d     = bus.rd_tag;
            valid_d   = 1'b0;
            if (EARLY_OUT && special) begin
                state_d   = DONE;
                res_d     = spec_val;
                cdb_tag_d = bus.rd_tag;
                valid_d   = 1'b1;
            end
        end

        if (bus.flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_val_q <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            cdb_tag_q <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_sel_q <= rem_sel_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            ovr_q     <= ovr_d;
            ovr_val_q <= ovr_val_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            cdb_tag_q <= cdb_tag_d;
            res_q     <= res_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.read_enable = read_en;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cdb_valid   = valid_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_result  = res_q;
    assign bus.cdb_branch  = 1'b0;
    assign bus.issue_done  = rst_n && valid_q && bus.cdb_grant && !bus.flush;

endmodule

// File: tb/tb_div_issue_iter.sv
// tb_div_issue_iter: directed self-checking bench for div_issue_iter.
module tb_div_issue_iter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 6;
    localparam int NORM_LAT = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = XLEN + 1;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[12];

    div_issue_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_issue_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op in an idle cycle; returns in cycle A+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input string name);
        bus.issue_queue_rdy = 1'b1;
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_tag   = tag;
        #1;
        check({name, "_re"}, bus.read_enable, 1);
        step();
        bus.issue_queue_rdy = 1'b0;
        check({name, "_busy"}, bus.busy, 1);
    endtask

    // Called in cycle A+1; counts cycles until cdb_valid (bounded).
    task automatic await_valid(input int exp_lat, input string name);
        int k;
        k = 1;
        while (!bus.cdb_valid && k < 100) begin
            step();
            k++;
        end
        check({name, "_lat"}, k, exp_lat);
    endtask

    task automatic retire(input logic [31:0] exp_res, input logic [5:0] exp_tag, input string name);
        check({name, "_res"}, bus.cdb_result, exp_res);
        check({name, "_tag"}, bus.cdb_tag, exp_tag);
        bus.cdb_grant = 1'b1;
        #1;
        check({name, "_done"}, bus.issue_done, 1);
        step();
        bus.cdb_grant = 1'b0;
        #1;
        check({name, "_vld_after"}, bus.cdb_valid, 0);
        check({name, "_done_after"}, bus.issue_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[2]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[3]  = '{OP_REMU, 32'd7,          32'd0,          32'd7,          1'b1};
        vecs[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[5]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[6]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[7]  = '{OP_DIV,  32'hFFFF_FFEC,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[8]  = '{OP_REM,  32'hFFFF_FFEC,  32'd0,          32'hFFFF_FFEC,  1'b1};
        vecs[9]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[10] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[11] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};

        rst_n               = 1'b0;
        bus.issue_queue_rdy = 1'b0;
        bus.op              = 2'b00;
        bus.rs1_data        = '0;
        bus.rs2_data        = '0;
        bus.rd_tag          = '0;
        bus.flush           = 1'b0;
        bus.cdb_grant       = 1'b0;

        // reset state
        step();
        step();
        check("rst_busy",   bus.busy, 0);
        check("rst_valid",  bus.cdb_valid, 0);
        check("rst_tag",    bus.cdb_tag, 0);
        check("rst_result", bus.cdb_result, 0);
        check("rst_branch", bus.cdb_branch, 0);
        check("rst_done",   bus.issue_done, 0);
        bus.issue_queue_rdy = 1'b1;
        #1;
        check("rst_re", bus.read_enable, 0);
        bus.issue_queue_rdy = 1'b0;
        rst_n = 1'b1;
        step();

        // directed op table
        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 6'(i + 1), nm);
            await_valid(vecs[i].spec ? SPEC_LAT : NORM_LAT, nm);
            retire(vecs[i].exp, 6'(i + 1), nm);
        end

        // held result without grant, then back-to-back accept on grant
        issue(OP_DIVU, 32'd100, 32'd7, 6'd9, "stall");
        await_valid(NORM_LAT, "stall");
        bus.issue_queue_rdy = 1'b1;
        bus.op       = OP_DIVU;
        bus.rs1_data = 32'd50;
        bus.rs2_data = 32'd5;
        bus.rd_tag   = 6'd10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_re",    bus.read_enable, 0);
            check("stall_valid", bus.cdb_valid, 1);
            check("stall_res",   bus.cdb_result, 14);
            check("stall_tag",   bus.cdb_tag, 9);
            check("stall_done",  bus.issue_done, 0);
            step();
        end
        bus.cdb_grant = 1'b1;
        #1;
        check("b2b_re",   bus.read_enable, 1);
        check("b2b_done", bus.issue_done, 1);
        step();
        bus.cdb_grant       = 1'b0;
        bus.issue_queue_rdy = 1'b0;
        #1;
        check("b2b_valid", bus.cdb_valid, 0);
        check("b2b_busy",  bus.busy, 1);
        await_valid(NORM_LAT, "b2b");
        retire(32'd10, 6'd10, "b2b");

        // flush at CALC cnt=10
        issue(OP_DIVU, 32'd1000, 32'd3, 6'd20, "flc");
        for (int i = 0; i < 10; i++) step();
        bus.flush           = 1'b1;
        bus.issue_queue_rdy = 1'b1;
        #1;
        check("flc_re", bus.read_enable, 0);
        step();
        bus.flush           = 1'b0;
        bus.issue_queue_rdy = 1'b0;
        #1;
        check("flc_busy",  bus.busy, 0);
        check("flc_valid", bus.cdb_valid, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.cdb_valid || bus.issue_done) seen++;
            step();
        end
        check("flc_quiet", seen, 0);

        // flush in DONE with grant
        issue(OP_DIVU, 32'd99, 32'd9, 6'd21, "fld");
        await_valid(NORM_LAT, "fld");
        bus.flush           = 1'b1;
        bus.cdb_grant       = 1'b1;
        bus.issue_queue_rdy = 1'b1;
        #1;
        check("fld_done", bus.issue_done, 0);
        check("fld_re",   bus.read_enable, 0);
        step();
        bus.flush           = 1'b0;
        bus.cdb_grant       = 1'b0;
        bus.issue_queue_rdy = 1'b0;
        #1;
        check("fld_busy",  bus.busy, 0);
        check("fld_valid", bus.cdb_valid, 0);

        // reset mid-CALC, then a clean op
        issue(OP_DIVU, 32'd77, 32'd7, 6'd30, "rmc");
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rmc_busy",   bus.busy, 0);
        check("rmc_valid",  bus.cdb_valid, 0);
        check("rmc_tag",    bus.cdb_tag, 0);
        check("rmc_result", bus.cdb_result, 0);
        check("rmc_branch", bus.cdb_branch, 0);
        check("rmc_done",   bus.issue_done, 0);
        step();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd33, "post");
        await_valid(NORM_LAT, "post");
        retire(32'hFFFF_FFFD, 6'd33, "post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
